cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 89 ++++++++
 rtl/cpu_sequencer_if.sv | 46 ++++
 rtl/branch_cond.sv | 24 ++
 rtl/cpu_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the CPU control sequencer.
// Holds the FSM state encoding, the decoded instruction class carried from
// DEC into the execute states, opcode/op field constants, branch condition
// codes and the mem_cmd / nsel / vsel / pc_sel output codes.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST    = 5'd0,
    S_IF1    = 5'd1,
    S_IF2    = 5'd2,
    S_UPD    = 5'd3,
    S_DEC    = 5'd4,
    S_GETA   = 5'd5,
    S_GETB   = 5'd6,
    S_EXEC   = 5'd7,
    S_WB     = 5'd8,
    S_ADDR   = 5'd9,
    S_MEMRD  = 5'd10,
    S_LDWB   = 5'd11,
    S_STGET  = 5'd12,
    S_STPASS = 5'd13,
    S_MEMWR  = 5'd14,
    S_LINK   = 5'd15,
    S_BXGET  = 5'd16,
    S_BXPASS = 5'd17,
    S_BRANCH = 5'd18,
    S_HALT   = 5'd19
  } state_e;

  // Instruction class latched in DEC so that every later output depends
  // only on registered state.
  typedef enum logic [3:0] {
    K_NONE = 4'd0,
    K_ALU  = 4'd1,
    K_CMP  = 4'd2,
    K_MVN  = 4'd3,
    K_MOV  = 4'd4,
    K_MOVI = 4'd5,
    K_LDR  = 4'd6,
    K_STR  = 4'd7,
    K_B    = 4'd8,
    K_BL   = 4'd9,
    K_BX   = 4'd10,
    K_BLX  = 4'd11
  } kind_e;

  // opcode field instruction[15:13]
  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_BL   = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field instruction[12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b00;
  localparam logic [1:0] OP_MOV_REG = 2'b10;
  localparam logic [1:0] OP_ALU_CMP = 2'b01;
  localparam logic [1:0] OP_ALU_MVN = 2'b11;
  localparam logic [1:0] OP_BL      = 2'b11;
  localparam logic [1:0] OP_BX      = 2'b00;
  localparam logic [1:0] OP_BLX     = 2'b10;

  // branch conditions instruction[10:8]
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_C   = 2'b10;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bundle between the control sequencer and the datapath.
// Inputs to the sequencer: instruction fields (opcode, op, cond) from the
// instruction register and the status flags Z/N/V.
// Outputs from the sequencer: register-file selects (nsel, vsel, write),
// datapath loads/selects, memory command/address select, PC/IR loads, halted.
// The master modport is the sequencer side; slave is the datapath side.
interface cpu_sequencer_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic       Z;
  logic       N;
  logic       V;

  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [1:0] mem_cmd;
  logic       addr_sel;
  logic       load_addr;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic [1:0] pc_sel;
  logic       halted;

  modport master (
    input  opcode, op, cond, Z, N, V,
    output nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
           mem_cmd, addr_sel, load_addr, load_ir, load_pc, reset_pc,
           pc_sel, halted
  );

  modport slave (
    output opcode, op, cond, Z, N, V,
    input  nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
           mem_cmd, addr_sel, load_addr, load_ir, load_pc, reset_pc,
           pc_sel, halted
  );
endinterface

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition evaluator.
// Ports: cond (3-bit condition code), Z/N/V status flags -> take.
// Unassigned condition codes never take.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic       take
);
  always_comb begin
    take = 1'b0;
    case (cond)
      COND_AL: take = 1'b1;
      COND_EQ: take = Z;
      COND_NE: take = ~Z;
      COND_LT: take = N ^ V;
      COND_LE: take = (N ^ V) | Z;
      default: take = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: Moore control FSM for a simple 16-bit CPU.
// Ports: clk, reset (synchronous, active-high), bus (cpu_sequencer_if.master:
// instruction fields and flags in, datapath/memory/PC controls out),
// state_dbg (current state, for observation).
// Parameters: MEM_WAIT extra wait cycles per memory access (0..15),
// EN_BRANCH enables opcodes 001/010 (otherwise they halt).
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT  = 0,
  parameter int EN_BRANCH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  cpu_sequencer_if.master        bus,
  output state_e                 state_dbg
);
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d;
  logic [3:0] wait_q, wait_d;
  logic       take;

  branch_cond u_cond (
    .cond (bus.cond),
    .Z    (bus.Z),
    .N    (bus.N),
    .V    (bus.V),
    .take (take)
  );

  always_ff @(posedge clk) begin
    state_q <= state_d;
    kind_q  <= kind_d;
    wait_q  <= wait_d;
  end

  assign state_dbg = state_q;

  // Next state. Memory states hold while the wait counter is non-zero.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1:  if (wait_q != 4'd0) wait_d = wait_q - 4'd1; else state_d = S_IF2;
      S_IF2:  state_d = S_UPD;
      S_UPD:  state_d = S_DEC;
      S_DEC: begin
        state_d = S_HALT;
        kind_d  = K_NONE;
        case (bus.opcode)
          OPC_MOV: begin
            if (bus.op == OP_MOV_REG) begin
              kind_d = K_MOV; state_d = S_GETB;
            end else if (bus.op == OP_MOV_IMM) begin
              kind_d = K_MOVI; state_d = S_WB;
            end
          end
          OPC_ALU: begin
            if (bus.op == OP_ALU_MVN) begin
              kind_d = K_MVN; state_d = S_GETB;
            end else if (bus.op == OP_ALU_CMP) begin
              kind_d = K_CMP; state_d = S_GETA;
            end else begin
              kind_d = K_ALU; state_d = S_GETA;
            end
          end
          OPC_LDR: begin kind_d = K_LDR; state_d = S_GETA; end
          OPC_STR: begin kind_d = K_STR; state_d = S_GETA; end
          OPC_B: begin
            if (EN_BRANCH != 0) begin
              kind_d  = K_B;
              state_d = take ? S_BRANCH : S_IF1;
            end
          end
          OPC_BL: begin
            if (EN_BRANCH != 0) begin
              case (bus.op)
                OP_BL:   begin kind_d = K_BL;  state_d = S_LINK;  end
                OP_BX:   begin kind_d = K_BX;  state_d = S_BXGET; end
                OP_BLX:  begin kind_d = K_BLX; state_d = S_LINK;  end
                default: state_d = S_HALT;
              endcase
            end
          end
          default: state_d = S_HALT;
        endcase
      end
      S_GETA:   state_d = (kind_q == K_LDR || kind_q == K_STR) ? S_ADDR : S_GETB;
      S_GETB:   state_d = S_EXEC;
      S_EXEC:   state_d = (kind_q == K_CMP) ? S_IF1 : S_WB;
      S_WB:     state_d = S_IF1;
      S_ADDR:   state_d = (kind_q == K_LDR) ? S_MEMRD : S_STGET;
      S_MEMRD:  if (wait_q != 4'd0) wait_d = wait_q - 4'd1; else state_d = S_LDWB;
      S_LDWB:   state_d = S_IF1;
      S_STGET:  state_d = S_STPASS;
      S_STPASS: state_d = S_MEMWR;
      S_MEMWR:  if (wait_q != 4'd0) wait_d = wait_q - 4'd1; else state_d = S_IF1;
      S_LINK:   state_d = (kind_q == K_BL) ? S_BRANCH : S_BXGET;
      S_BXGET:  state_d = S_BXPASS;
      S_BXPASS: state_d = S_BRANCH;
      S_BRANCH: state_d = S_IF1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase

    // Fresh wait budget on every entry into a memory-access state.
    if (state_d != state_q &&
        (state_d == S_IF1 || state_d == S_MEMRD || state_d == S_MEMWR))
      wait_d = WAIT_INIT;

    if (reset) begin
      state_d = S_RST;
      kind_d  = K_NONE;
      wait_d  = 4'd0;
    end
  end

  // Moore outputs from state_q and the latched instruction class.
  always_comb begin
    bus.nsel      = 3'b000;
    bus.vsel      = VSEL_C;
    bus.write     = 1'b0;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.mem_cmd   = MEM_NONE;
    bus.addr_sel  = 1'b0;
    bus.load_addr = 1'b0;
    bus.load_ir   = 1'b0;
    bus.load_pc   = 1'b0;
    bus.reset_pc  = 1'b0;
    bus.pc_sel    = PC_INC;
    bus.halted    = 1'b0;
    unique case (state_q)
      S_RST:  begin bus.reset_pc = 1'b1; bus.load_pc = 1'b1; end
      S_IF1:  begin bus.addr_sel = 1'b1; bus.mem_cmd = MEM_RD; end
      S_IF2:  begin bus.addr_sel = 1'b1; bus.mem_cmd = MEM_RD; bus.load_ir = 1'b1; end
      S_UPD:  begin bus.load_pc = 1'b1; bus.pc_sel = PC_INC; end
      S_DEC:  ;
      S_GETA: begin bus.nsel = NSEL_RN; bus.loada = 1'b1; end
      S_GETB: begin bus.nsel = NSEL_RM; bus.loadb = 1'b1; end
      S_EXEC: begin
        if (kind_q == K_CMP) begin
          bus.loads = 1'b1;
        end else begin
          bus.loadc = 1'b1;
          bus.asel  = (kind_q == K_MOV || kind_q == K_MVN);
        end
      end
      S_WB: begin
        bus.write = 1'b1;
        if (kind_q == K_MOVI) begin
          bus.nsel = NSEL_RN; bus.vsel = VSEL_IMM;
        end else begin
          bus.nsel = NSEL_RD; bus.vsel = VSEL_C;
        end
      end
      S_ADDR: begin
        bus.bsel = 1'b1; bus.loadc = 1'b1; bus.load_addr = 1'b1; bus.addr_sel = 1'b0;
      end
      S_MEMRD: begin bus.mem_cmd = MEM_RD; bus.addr_sel = 1'b0; end
      S_LDWB: begin
        bus.nsel = NSEL_RD; bus.vsel = VSEL_MDATA; bus.write = 1'b1; bus.mem_cmd = MEM_RD;
      end
      S_STGET:  begin bus.nsel = NSEL_RD; bus.loadb = 1'b1; end
      S_STPASS: begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      S_MEMWR:  begin bus.mem_cmd = MEM_WR; bus.addr_sel = 1'b0; end
      S_LINK:   begin bus.nsel = NSEL_RN; bus.vsel = VSEL_PC; bus.write = 1'b1; end
      S_BXGET:  begin bus.nsel = NSEL_RD; bus.loadb = 1'b1; end
      S_BXPASS: begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      // BRANCH doubles as the PC-load cycle of BX/BLX, taking the target from C.
      S_BRANCH: begin
        bus.load_pc = 1'b1;
        bus.pc_sel  = (kind_q == K_BX || kind_q == K_BLX) ? PC_C : PC_REL;
      end
      S_HALT:   bus.halted = 1'b1;
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for cpu_sequencer.
// Four instances: d0 (MEM_WAIT=0), d1 (MEM_WAIT=3), d2 (MEM_WAIT=5),
// d3 (MEM_WAIT=0, EN_BRANCH=0), each with its own reset and interface.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  // Packed control word: {nsel, vsel, write, loada, loadb, loadc, loads, asel,
  // bsel, mem_cmd, addr_sel, load_addr, load_ir, load_pc, reset_pc, pc_sel, halted}
  localparam logic [21:0] C_RN  = 22'd1 << 19;
  localparam logic [21:0] C_RD  = 22'd2 << 19;
  localparam logic [21:0] C_RM  = 22'd4 << 19;
  localparam logic [21:0] V_PC  = 22'd1 << 17;
  localparam logic [21:0] V_IMM = 22'd2 << 17;
  localparam logic [21:0] V_MD  = 22'd3 << 17;
  localparam logic [21:0] WR    = 22'd1 << 16;
  localparam logic [21:0] LA    = 22'd1 << 15;
  localparam logic [21:0] LB    = 22'd1 << 14;
  localparam logic [21:0] LC    = 22'd1 << 13;
  localparam logic [21:0] LS    = 22'd1 << 12;
  localparam logic [21:0] AS    = 22'd1 << 11;
  localparam logic [21:0] BS    = 22'd1 << 10;
  localparam logic [21:0] MRD   = 22'd1 << 8;
  localparam logic [21:0] MWR   = 22'd2 << 8;
  localparam logic [21:0] APC   = 22'd1 << 7;
  localparam logic [21:0] LADDR = 22'd1 << 6;
  localparam logic [21:0] LIR   = 22'd1 << 5;
  localparam logic [21:0] LPC   = 22'd1 << 4;
  localparam logic [21:0] RPC   = 22'd1 << 3;
  localparam logic [21:0] P_REL = 22'd1 << 1;
  localparam logic [21:0] P_C   = 22'd2 << 1;
  localparam logic [21:0] HLT   = 22'd1;

  localparam logic [21:0] E_RST    = RPC | LPC;
  localparam logic [21:0] E_IF1    = APC | MRD;
  localparam logic [21:0] E_IF2    = APC | MRD | LIR;
  localparam logic [21:0] E_UPD    = LPC;
  localparam logic [21:0] E_DEC    = 22'd0;
  localparam logic [21:0] E_WBI    = C_RN | V_IMM | WR;
  localparam logic [21:0] E_WB     = C_RD | WR;
  localparam logic [21:0] E_GETA   = C_RN | LA;
  localparam logic [21:0] E_GETB   = C_RM | LB;
  localparam logic [21:0] E_EXEC   = LC;
  localparam logic [21:0] E_EXMOV  = LC | AS;
  localparam logic [21:0] E_EXCMP  = LS;
  localparam logic [21:0] E_ADDR   = BS | LC | LADDR;
  localparam logic [21:0] E_MEMRD  = MRD;
  localparam logic [21:0] E_LDWB   = C_RD | V_MD | WR | MRD;
  localparam logic [21:0] E_STGET  = C_RD | LB;
  localparam logic [21:0] E_STPASS = AS | LC;
  localparam logic [21:0] E_MEMWR  = MWR;
  localparam logic [21:0] E_LINK   = C_RN | V_PC | WR;
  localparam logic [21:0] E_BXGET  = C_RD | LB;
  localparam logic [21:0] E_BXPASS = AS | LC;
  localparam logic [21:0] E_BR     = LPC | P_REL;
  localparam logic [21:0] E_BRC    = LPC | P_C;
  localparam logic [21:0] E_HALT   = HLT;

  // clock / reset
  logic       clk = 1'b0;
  logic [3:0] rst = 4'hF;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  cpu_sequencer_if b0 ();
  cpu_sequencer_if b1 ();
  cpu_sequencer_if b2 ();
  cpu_sequencer_if b3 ();
  state_e st0, st1, st2, st3;

  cpu_sequencer #(.MEM_WAIT(0), .EN_BRANCH(1)) d0 (.clk(clk), .reset(rst[0]), .bus(b0.master), .state_dbg(st0));
  cpu_sequencer #(.MEM_WAIT(3), .EN_BRANCH(1)) d1 (.clk(clk), .reset(rst[1]), .bus(b1.master), .state_dbg(st1));
  cpu_sequencer #(.MEM_WAIT(5), .EN_BRANCH(1)) d2 (.clk(clk), .reset(rst[2]), .bus(b2.master), .state_dbg(st2));
  cpu_sequencer #(.MEM_WAIT(0), .EN_BRANCH(0)) d3 (.clk(clk), .reset(rst[3]), .bus(b3.master), .state_dbg(st3));

  logic [21:0] ctl_a [4];
  state_e      st_a  [4];
  assign st_a[0] = st0;
  assign st_a[1] = st1;
  assign st_a[2] = st2;
  assign st_a[3] = st3;
  assign ctl_a[0] = {b0.nsel, b0.vsel, b0.write, b0.loada, b0.loadb, b0.loadc, b0.loads, b0.asel, b0.bsel,
                     b0.mem_cmd, b0.addr_sel, b0.load_addr, b0.load_ir, b0.load_pc, b0.reset_pc, b0.pc_sel, b0.halted};
  assign ctl_a[1] = {b1.nsel, b1.vsel, b1.write, b1.loada, b1.loadb, b1.loadc, b1.loads, b1.asel, b1.bsel,
                     b1.mem_cmd, b1.addr_sel, b1.load_addr, b1.load_ir, b1.load_pc, b1.reset_pc, b1.pc_sel, b1.halted};
  assign ctl_a[2] = {b2.nsel, b2.vsel, b2.write, b2.loada, b2.loadb, b2.loadc, b2.loads, b2.asel, b2.bsel,
                     b2.mem_cmd, b2.addr_sel, b2.load_addr, b2.load_ir, b2.load_pc, b2.reset_pc, b2.pc_sel, b2.halted};
  assign ctl_a[3] = {b3.nsel, b3.vsel, b3.write, b3.loada, b3.loadb, b3.loadc, b3.loads, b3.asel, b3.bsel,
                     b3.mem_cmd, b3.addr_sel, b3.load_addr, b3.load_ir, b3.load_pc, b3.reset_pc, b3.pc_sel, b3.halted};

  // driver tasks
  task automatic set_ins(input int id, input logic [2:0] opc, input logic [1:0] op,
                         input logic [2:0] cnd, input logic z, input logic n, input logic v);
    case (id)
      0: begin b0.opcode = opc; b0.op = op; b0.cond = cnd; b0.Z = z; b0.N = n; b0.V = v; end
      1: begin b1.opcode = opc; b1.op = op; b1.cond = cnd; b1.Z = z; b1.N = n; b1.V = v; end
      2: begin b2.opcode = opc; b2.op = op; b2.cond = cnd; b2.Z = z; b2.N = n; b2.V = v; end
      default: begin b3.opcode = opc; b3.op = op; b3.cond = cnd; b3.Z = z; b3.N = n; b3.V = v; end
    endcase
  endtask

  task automatic chk(input int id, input state_e es, input logic [21:0] ec, input string tag);
    state_e      st;
    logic [21:0] c;
    st = st_a[id];
    c  = ctl_a[id];
    n_cmp++;
    assert (st === es) else begin
      n_err++;
      $error("FAIL %s state: got %s, want %s", tag, st.name(), es.name());
    end
    n_cmp++;
    assert (c === ec) else begin
      n_err++;
      $error("FAIL %s ctl: got %h, want %h", tag, c, ec);
    end
  endtask

  task automatic step(input int id, input state_e es, input logic [21:0] ec, input string tag);
    @(posedge clk); #1;
    chk(id, es, ec, tag);
  endtask

  task automatic do_reset(input int id, input string tag);
    rst[id] = 1'b1;
    @(posedge clk); #1;
    rst[id] = 1'b0;
    chk(id, S_RST, E_RST, tag);
  endtask

  // From IF1 on a zero-wait instance: IF2, UPD, DEC.
  task automatic fetch0(input string tag);
    step(0, S_IF2, E_IF2, {tag, "/if2"});
    step(0, S_UPD, E_UPD, {tag, "/upd"});
    step(0, S_DEC, E_DEC, {tag, "/dec"});
  endtask

  initial begin
    set_ins(0, OPC_MOV, OP_MOV_IMM, 3'd0, 1'b0, 1'b0, 1'b0);
    set_ins(1, OPC_LDR, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    set_ins(2, OPC_STR, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    set_ins(3, OPC_B,   2'b00, COND_AL, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 4'h0;

    // MOV Rn,#imm: RST IF1 IF2 UPD DEC WB, back to IF1 at cycle 7
    do_reset(0, "movi/rst");
    step(0, S_IF1, E_IF1, "movi/if1");
    fetch0("movi");
    step(0, S_WB, E_WBI, "movi/wb");
    step(0, S_IF1, E_IF1, "movi/ret");

    // ADD
    set_ins(0, OPC_ALU, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("add");
    step(0, S_GETA, E_GETA, "add/geta");
    step(0, S_GETB, E_GETB, "add/getb");
    step(0, S_EXEC, E_EXEC, "add/exec");
    step(0, S_WB,   E_WB,   "add/wb");
    step(0, S_IF1,  E_IF1,  "add/ret");

    // MVN skips GETA, asel in EXEC
    set_ins(0, OPC_ALU, OP_ALU_MVN, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("mvn");
    step(0, S_GETB, E_GETB,  "mvn/getb");
    step(0, S_EXEC, E_EXMOV, "mvn/exec");
    step(0, S_WB,   E_WB,    "mvn/wb");
    step(0, S_IF1,  E_IF1,   "mvn/ret");

    // CMP: loads only, no writeback
    set_ins(0, OPC_ALU, OP_ALU_CMP, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("cmp");
    step(0, S_GETA, E_GETA,  "cmp/geta");
    step(0, S_GETB, E_GETB,  "cmp/getb");
    step(0, S_EXEC, E_EXCMP, "cmp/exec");
    step(0, S_IF1,  E_IF1,   "cmp/ret");

    // MOV Rd,Rm
    set_ins(0, OPC_MOV, OP_MOV_REG, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("movr");
    step(0, S_GETB, E_GETB,  "movr/getb");
    step(0, S_EXEC, E_EXMOV, "movr/exec");
    step(0, S_WB,   E_WB,    "movr/wb");
    step(0, S_IF1,  E_IF1,   "movr/ret");

    // LDR, zero wait
    set_ins(0, OPC_LDR, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("ldr");
    step(0, S_GETA,  E_GETA,  "ldr/geta");
    step(0, S_ADDR,  E_ADDR,  "ldr/addr");
    step(0, S_MEMRD, E_MEMRD, "ldr/memrd");
    step(0, S_LDWB,  E_LDWB,  "ldr/ldwb");
    step(0, S_IF1,   E_IF1,   "ldr/ret");

    // STR, zero wait
    set_ins(0, OPC_STR, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("str");
    step(0, S_GETA,   E_GETA,   "str/geta");
    step(0, S_ADDR,   E_ADDR,   "str/addr");
    step(0, S_STGET,  E_STGET,  "str/stget");
    step(0, S_STPASS, E_STPASS, "str/stpass");
    step(0, S_MEMWR,  E_MEMWR,  "str/memwr");
    step(0, S_IF1,    E_IF1,    "str/ret");

    // BEQ not taken (Z=0), then taken (Z=1)
    set_ins(0, OPC_B, 2'b00, COND_EQ, 1'b0, 1'b0, 1'b0);
    fetch0("beq0");
    step(0, S_IF1, E_IF1, "beq0/ret");
    set_ins(0, OPC_B, 2'b00, COND_EQ, 1'b1, 1'b0, 1'b0);
    fetch0("beq1");
    step(0, S_BRANCH, E_BR, "beq1/br");
    step(0, S_IF1, E_IF1, "beq1/ret");

    // BNE taken with Z=0; BLT taken N!=V; BLT not taken N==V;
    // BLE taken on Z alone; cond 101 never taken
    set_ins(0, OPC_B, 2'b00, COND_NE, 1'b0, 1'b0, 1'b0);
    fetch0("bne");
    step(0, S_BRANCH, E_BR, "bne/br");
    step(0, S_IF1, E_IF1, "bne/ret");
    set_ins(0, OPC_B, 2'b00, COND_LT, 1'b0, 1'b1, 1'b0);
    fetch0("blt1");
    step(0, S_BRANCH, E_BR, "blt1/br");
    step(0, S_IF1, E_IF1, "blt1/ret");
    set_ins(0, OPC_B, 2'b00, COND_LT, 1'b0, 1'b1, 1'b1);
    fetch0("blt0");
    step(0, S_IF1, E_IF1, "blt0/ret");
    set_ins(0, OPC_B, 2'b00, COND_LE, 1'b1, 1'b0, 1'b0);
    fetch0("ble");
    step(0, S_BRANCH, E_BR, "ble/br");
    step(0, S_IF1, E_IF1, "ble/ret");
    set_ins(0, OPC_B, 2'b00, 3'b101, 1'b1, 1'b1, 1'b0);
    fetch0("bc5");
    step(0, S_IF1, E_IF1, "bc5/ret");

    // BL
    set_ins(0, OPC_BL, OP_BL, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("bl");
    step(0, S_LINK,   E_LINK, "bl/link");
    step(0, S_BRANCH, E_BR,   "bl/br");
    step(0, S_IF1,    E_IF1,  "bl/ret");

    // BX
    set_ins(0, OPC_BL, OP_BX, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("bx");
    step(0, S_BXGET,  E_BXGET,  "bx/get");
    step(0, S_BXPASS, E_BXPASS, "bx/pass");
    step(0, S_BRANCH, E_BRC,    "bx/pc");
    step(0, S_IF1,    E_IF1,    "bx/ret");

    // BLX
    set_ins(0, OPC_BL, OP_BLX, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("blx");
    step(0, S_LINK,   E_LINK,   "blx/link");
    step(0, S_BXGET,  E_BXGET,  "blx/get");
    step(0, S_BXPASS, E_BXPASS, "blx/pass");
    step(0, S_BRANCH, E_BRC,    "blx/pc");
    step(0, S_IF1,    E_IF1,    "blx/ret");

    // illegal 010/01 halts
    set_ins(0, OPC_BL, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0);
    fetch0("ill");
    step(0, S_HALT, E_HALT, "ill/halt");

    // 111 halts and stays there 20 cycles, then reset exits
    set_ins(0, OPC_HALT, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    do_reset(0, "hlt/rst");
    step(0, S_IF1, E_IF1, "hlt/if1");
    fetch0("hlt");
    for (int i = 0; i < 20; i++) step(0, S_HALT, E_HALT, "hlt/hold");
    do_reset(0, "hlt/exit");
    step(0, S_IF1, E_IF1, "hlt/if1b");

    // MEM_WAIT=3: IF1 four cycles, LDR MEMRD four cycles
    do_reset(1, "w3/rst");
    for (int i = 0; i < 4; i++) step(1, S_IF1, E_IF1, "w3/if1");
    step(1, S_IF2,  E_IF2,  "w3/if2");
    step(1, S_UPD,  E_UPD,  "w3/upd");
    step(1, S_DEC,  E_DEC,  "w3/dec");
    step(1, S_GETA, E_GETA, "w3/geta");
    step(1, S_ADDR, E_ADDR, "w3/addr");
    for (int i = 0; i < 4; i++) step(1, S_MEMRD, E_MEMRD, "w3/memrd");
    step(1, S_LDWB, E_LDWB, "w3/ldwb");
    for (int i = 0; i < 4; i++) step(1, S_IF1, E_IF1, "w3/if1b");
    step(1, S_IF2,  E_IF2,  "w3/if2b");

    // MEM_WAIT=5: reset lands mid MEMWR; next IF1 gets a full six cycles
    do_reset(2, "w5/rst");
    for (int i = 0; i < 6; i++) step(2, S_IF1, E_IF1, "w5/if1");
    step(2, S_IF2,    E_IF2,    "w5/if2");
    step(2, S_UPD,    E_UPD,    "w5/upd");
    step(2, S_DEC,    E_DEC,    "w5/dec");
    step(2, S_GETA,   E_GETA,   "w5/geta");
    step(2, S_ADDR,   E_ADDR,   "w5/addr");
    step(2, S_STGET,  E_STGET,  "w5/stget");
    step(2, S_STPASS, E_STPASS, "w5/stpass");
    step(2, S_MEMWR,  E_MEMWR,  "w5/memwr");
    step(2, S_MEMWR,  E_MEMWR,  "w5/memwr2");
    do_reset(2, "w5/midrst");
    for (int i = 0; i < 6; i++) step(2, S_IF1, E_IF1, "w5/if1b");
    step(2, S_IF2, E_IF2, "w5/if2b");

    // EN_BRANCH=0: always-taken B decodes as illegal
    do_reset(3, "nb/rst");
    step(3, S_IF1,  E_IF1,  "nb/if1");
    step(3, S_IF2,  E_IF2,  "nb/if2");
    step(3, S_UPD,  E_UPD,  "nb/upd");
    step(3, S_DEC,  E_DEC,  "nb/dec");
    step(3, S_HALT, E_HALT, "nb/halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
